// File: rtl/gray_counter_pkg.sv
// gray_counter_pkg: shared Gray-code helpers and direction encoding.
// Reused by the async FIFO pointer logic as well as by gray_counter.
package gray_counter_pkg;

    // Widest code the helper functions handle; narrower callers zero-extend
    // their operand and keep the low bits of the result.
    localparam int GC_MAX_WIDTH = 64;

    // Encoding of the up_dn input.
    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Binary to reflected Gray: g[i] = b[i+1] ^ b[i], g[msb] = b[msb].
    // Zero-extension leaves the low bits of the result unchanged.
    function automatic logic [GC_MAX_WIDTH-1:0] bin2gray(input logic [GC_MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GC_MAX_WIDTH-1:0] gray2bin(input logic [GC_MAX_WIDTH-1:0] g);
        logic [GC_MAX_WIDTH-1:0] b;
        b[GC_MAX_WIDTH-1] = g[GC_MAX_WIDTH-1];
        for (int i = GC_MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : gray_counter_pkg

// File: rtl/bin2gray_comb.sv
// bin2gray_comb: purely combinational WIDTH-wide binary-to-Gray converter.
// Sits on the counter's next-state path so the Gray register loads in the
// same edge as the binary register.
module bin2gray_comb #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    // Each Gray bit is the XOR of its binary bit and the next-higher one.
    always_comb begin
        gray_o[WIDTH-1] = bin_i[WIDTH-1];
        for (int i = 0; i < WIDTH - 1; i++) begin
            gray_o[i] = bin_i[i+1] ^ bin_i[i];
        end
    end

endmodule : bin2gray_comb

// File: rtl/gray_counter.sv
// gray_counter: up/down counter with enable and parallel load that exports
// both the registered binary count and its registered Gray code, plus a
// one-cycle wrap pulse.
// Build option: define GRAY_SATURATE_EN to make the counter stop at the
// ends of its range instead of wrapping; wrap then flags each blocked step.
// WIDTH must be >= 2 and RST_VAL must fit in WIDTH bits.
module gray_counter
    import gray_counter_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    localparam logic [GC_MAX_WIDTH-1:0] RST_GRAY_FULL = bin2gray(GC_MAX_WIDTH'(RST_VAL));
    localparam logic [WIDTH-1:0]        RST_GRAY      = RST_GRAY_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             at_max, at_min;

    assign at_max = (bin_q == {WIDTH{1'b1}});
    assign at_min = (bin_q == {WIDTH{1'b0}});

    // Next binary value and wrap flag: load beats enable; idle holds the count.
    always_comb begin
        // NOTE: every signal gets a default first so no path through this block leaves it unassigned, which would infer a latch.
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            if (up_dn == DIR_UP) begin
                wrap_d = at_max;
`ifdef GRAY_SATURATE_EN
                if (!at_max) bin_d = bin_q + 1'b1;
`else
                bin_d = bin_q + 1'b1;
`endif
            end else begin
                wrap_d = at_min;
`ifdef GRAY_SATURATE_EN
                if (!at_min) bin_d = bin_q - 1'b1;
`else
                bin_d = bin_q - 1'b1;
`endif
            end
        end
    end

    // Gray code of the next count, so both registers update in the same edge.
    bin2gray_comb #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin_i  (bin_d),
        .gray_o (gray_d)
    );

    // Output registers with synchronous reset; reset overrides load and enable.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values, like real flops.
        if (rst) begin
            bin_q  <= RST_VAL;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

endmodule : gray_counter

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed test of gray_counter (WIDTH = 4), with a second
// instance at RST_VAL = 5 for the reset value. Expectations follow the build:
// define GRAY_SATURATE_EN for the saturating variant.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_bin;
    logic [3:0] bin_out,  gray_out;
    logic       wrap;
    logic [3:0] bin_out5, gray_out5;
    logic       wrap5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(4), .RST_VAL(4'd0)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_bin(load_bin), .bin_out(bin_out), .gray_out(gray_out), .wrap(wrap)
    );

    gray_counter #(.WIDTH(4), .RST_VAL(4'd5)) dut5 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_bin(load_bin), .bin_out(bin_out5), .gray_out(gray_out5), .wrap(wrap5)
    );

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_bin = 4'd0;
        tick();
        tick();
        n_checks++;
        if ({bin_out, gray_out, wrap} !== {4'd0, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset0: got bin=%0d gray=%b wrap=%b, want bin=0 gray=0000 wrap=0", bin_out, gray_out, wrap);
        end
        n_checks++;
        if ({bin_out5, gray_out5, wrap5} !== {4'd5, 4'b0111, 1'b0}) begin
            n_fail++;
            $display("FAIL reset5: got bin=%0d gray=%b wrap=%b, want bin=5 gray=0111 wrap=0", bin_out5, gray_out5, wrap5);
        end
        rst = 1'b0;
    endtask

    task automatic test_up_sweep();
        // Hand-computed Gray codes of 1..15 then 0.
        logic [3:0] exp_gray [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                                      4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                      4'b1011, 4'b1001, 4'b1000, 4'b0000};
        logic [3:0] eb, eg;
        logic       ew;
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            eb = 4'(i + 1);
            eg = exp_gray[i];
            ew = (i == 15);
`ifdef GRAY_SATURATE_EN
            if (i == 15) begin eb = 4'd15; eg = 4'b1000; end
`endif
            n_checks++;
            if ({bin_out, gray_out, wrap} !== {eb, eg, ew}) begin
                n_fail++;
                $display("FAIL up_sweep[%0d]: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                         i, bin_out, gray_out, wrap, eb, eg, ew);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_down_wrap();
        logic [3:0] eb [3];
        logic [3:0] eg [3];
        logic       ew [3];
        load = 1'b1; load_bin = 4'd0; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
`ifdef GRAY_SATURATE_EN
        eb = '{4'd0, 4'd0, 4'd0};
        eg = '{4'b0000, 4'b0000, 4'b0000};
        ew = '{1'b0, 1'b1, 1'b1};
`else
        eb = '{4'd0, 4'd15, 4'd14};
        eg = '{4'b0000, 4'b1000, 4'b1001};
        ew = '{1'b0, 1'b1, 1'b0};
`endif
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            n_checks++;
            if ({bin_out, gray_out, wrap} !== {eb[i], eg[i], ew[i]}) begin
                n_fail++;
                $display("FAIL down_wrap[%0d]: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                         i, bin_out, gray_out, wrap, eb[i], eg[i], ew[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_priority();
        load = 1'b1; load_bin = 4'd9; en = 1'b1; up_dn = 1'b1;
        tick();
        n_checks++;
        if ({bin_out, gray_out, wrap} !== {4'd9, 4'b1101, 1'b0}) begin
            n_fail++;
            $display("FAIL load_over_en: got bin=%0d gray=%b wrap=%b, want bin=9 gray=1101 wrap=0", bin_out, gray_out, wrap);
        end
        rst = 1'b1; load_bin = 4'd12;
        tick();
        n_checks++;
        if ({bin_out, gray_out, wrap} !== {4'd0, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_over_load: got bin=%0d gray=%b wrap=%b, want bin=0 gray=0000 wrap=0", bin_out, gray_out, wrap);
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_hold_and_direction();
        // Idle holds, then up, up, down, down with no dead cycle.
        logic       en_v [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       ud_v [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] eb   [6] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd1, 4'd0};
        logic [3:0] eg   [6] = '{4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b0001, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            en = en_v[i]; up_dn = ud_v[i];
            tick();
            n_checks++;
            if ({bin_out, gray_out, wrap} !== {eb[i], eg[i], 1'b0}) begin
                n_fail++;
                $display("FAIL hold_dir[%0d]: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=0",
                         i, bin_out, gray_out, wrap, eb[i], eg[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_mid_reset();
        en = 1'b1; up_dn = 1'b1;
        repeat (6) tick();
        n_checks++;
        if ({bin_out, gray_out} !== {4'd6, 4'b0101}) begin
            n_fail++;
            $display("FAIL mid_count6: got bin=%0d gray=%b, want bin=6 gray=0101", bin_out, gray_out);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({bin_out, gray_out, wrap} !== {4'd0, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_rst: got bin=%0d gray=%b wrap=%b, want bin=0 gray=0000 wrap=0", bin_out, gray_out, wrap);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if ({bin_out, gray_out} !== {4'd1, 4'b0001}) begin
            n_fail++;
            $display("FAIL after_rst: got bin=%0d gray=%b, want bin=1 gray=0001", bin_out, gray_out);
        end
        en = 1'b0;
    endtask

    task automatic test_top_end();
        // Load 15 (wrap must stay low on a load), then 3 up steps, then one down step.
        logic [3:0] eb [4];
        logic [3:0] eg [4];
        logic       ew [4];
        load = 1'b1; load_bin = 4'd15; en = 1'b0;
        tick();
        load = 1'b0;
        n_checks++;
        if ({bin_out, gray_out, wrap} !== {4'd15, 4'b1000, 1'b0}) begin
            n_fail++;
            $display("FAIL load15: got bin=%0d gray=%b wrap=%b, want bin=15 gray=1000 wrap=0", bin_out, gray_out, wrap);
        end
`ifdef GRAY_SATURATE_EN
        eb = '{4'd15, 4'd15, 4'd15, 4'd14};
        eg = '{4'b1000, 4'b1000, 4'b1000, 4'b1001};
        ew = '{1'b1, 1'b1, 1'b1, 1'b0};
`else
        eb = '{4'd0, 4'd1, 4'd2, 4'd1};
        eg = '{4'b0000, 4'b0001, 4'b0011, 4'b0001};
        ew = '{1'b1, 1'b0, 1'b0, 1'b0};
`endif
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_dn = (i < 3) ? 1'b1 : 1'b0;
            tick();
            n_checks++;
            if ({bin_out, gray_out, wrap} !== {eb[i], eg[i], ew[i]}) begin
                n_fail++;
                $display("FAIL top_end[%0d]: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                         i, bin_out, gray_out, wrap, eb[i], eg[i], ew[i]);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_sweep();
        test_down_wrap();
        test_priority();
        test_hold_and_direction();
        test_mid_reset();
        test_top_end();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_gray_counter
